// File: rtl/logic_axi4_stream_packet_generator_if.sv
// AXI4-Stream transmit bundle: master drives payload/framing, slave returns tready.
interface logic_axi4_stream_packet_generator_if #(
  parameter int TDATA_BYTES = 4,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1
);
  logic                     tvalid;
  logic                     tready;
  logic                     tlast;
  logic [TDATA_BYTES*8-1:0] tdata;
  logic [TDATA_BYTES-1:0]   tkeep;
  logic [TDATA_BYTES-1:0]   tstrb;
  logic [TDEST_WIDTH-1:0]   tdest;
  logic [TUSER_WIDTH-1:0]   tuser;
  logic [TID_WIDTH-1:0]     tid;

  modport master (output tvalid, tlast, tdata, tkeep, tstrb, tdest, tuser, tid, input tready);
  modport slave  (input tvalid, tlast, tdata, tkeep, tstrb, tdest, tuser, tid, output tready);
endinterface

// File: rtl/logic_axi4_stream_packet_generator.sv
// Deterministic AXI4-Stream packet source; first beat one cycle after start, fully registered.
// Beats advance only on tvalid&&tready; a stalled beat is held unchanged until accepted.
module logic_axi4_stream_packet_generator #(
  parameter int TDATA_BYTES  = 4,
  parameter int TDEST_WIDTH  = 1,
  parameter int TUSER_WIDTH  = 1,
  parameter int TID_WIDTH    = 1,
  parameter bit USE_TKEEP    = 1'b1,
  parameter bit USE_TSTRB    = 1'b1,
  parameter bit USE_TLAST    = 1'b1,
  parameter int LENGTH_WIDTH = 16
) (
  input  logic                    aclk,
  input  logic                    sreset,
  input  logic                    start,
  input  logic                    stop,
  input  logic [LENGTH_WIDTH-1:0] cfg_length,
  input  logic [LENGTH_WIDTH-1:0] cfg_count,
  input  logic [7:0]              cfg_seed,
  input  logic [TDEST_WIDTH-1:0]  cfg_tdest,
  input  logic [TID_WIDTH-1:0]    cfg_tid,
  output logic                    busy,
  output logic                    done,
  output logic [LENGTH_WIDTH-1:0] packets_sent,
  logic_axi4_stream_packet_generator_if.master tx
);
  localparam int LW = LENGTH_WIDTH;
  localparam int DW = TDATA_BYTES * 8;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state;
  logic [LW-1:0]          count_q, last_beat_q, rem_q, beat_k;
  logic [7:0]             pkt_base, beat_base;
  logic                   last_q, stop_q;
  logic                   tvalid_r, tlast_r;
  logic [DW-1:0]          tdata_r;
  logic [TDATA_BYTES-1:0] tkeep_r;
  logic [TDEST_WIDTH-1:0] tdest_r;
  logic [TUSER_WIDTH-1:0] tuser_r;
  logic [TID_WIDTH-1:0]   tid_r;

  logic                   hs, pkt_end, run_end, nb_last;
  logic [LW-1:0]          sent_inc, nb_k, st_last_beat, st_rem;
  logic [7:0]             nb_base;
  logic [TDATA_BYTES-1:0] nb_keep, st_keep;

  // rem==0 on the last beat means the packet filled it exactly.
  function automatic logic [TDATA_BYTES-1:0] beat_keep(input logic last, input logic [LW-1:0] rem);
    logic [TDATA_BYTES-1:0] k;
    for (int b = 0; b < TDATA_BYTES; b++)
      k[b] = !last || (rem == '0) || (LW'(b) < rem);
    return k;
  endfunction

  function automatic logic [DW-1:0] beat_data(input logic [7:0] base, input logic [TDATA_BYTES-1:0] keep);
    logic [DW-1:0] d;
    for (int b = 0; b < TDATA_BYTES; b++)
      d[b*8 +: 8] = keep[b] ? (base + 8'(b)) : 8'h00;
    return d;
  endfunction

  always_comb begin
    hs           = tvalid_r && tx.tready;
    pkt_end      = hs && last_q;
    sent_inc     = packets_sent + LW'(1);
    run_end      = pkt_end && (((count_q != '0) && (sent_inc == count_q)) || stop_q || stop);
    nb_base      = pkt_end ? (pkt_base + 8'd1) : (beat_base + 8'(TDATA_BYTES));
    nb_k         = pkt_end ? '0 : (beat_k + LW'(1));
    nb_last      = (nb_k == last_beat_q);
    nb_keep      = beat_keep(nb_last, rem_q);
    st_last_beat = (cfg_length - LW'(1)) / LW'(TDATA_BYTES);
    st_rem       = cfg_length % LW'(TDATA_BYTES);
    st_keep      = beat_keep(st_last_beat == '0, st_rem);
  end

  always_ff @(posedge aclk) begin
    if (sreset) begin
      state        <= IDLE;
      count_q      <= '0;
      last_beat_q  <= '0;
      rem_q        <= '0;
      beat_k       <= '0;
      pkt_base     <= '0;
      beat_base    <= '0;
      last_q       <= 1'b0;
      stop_q       <= 1'b0;
      tvalid_r     <= 1'b0;
      tlast_r      <= 1'b0;
      tdata_r      <= '0;
      tkeep_r      <= '0;
      tdest_r      <= '0;
      tuser_r      <= '0;
      tid_r        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      packets_sent <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            packets_sent <= '0;
            if (cfg_length == '0) begin
              done <= 1'b1;
            end else begin
              state       <= SEND;
              busy        <= 1'b1;
              stop_q      <= 1'b0;
              count_q     <= cfg_count;
              last_beat_q <= st_last_beat;
              rem_q       <= st_rem;
              beat_k      <= '0;
              pkt_base    <= cfg_seed;
              beat_base   <= cfg_seed;
              last_q      <= (st_last_beat == '0);
              tvalid_r    <= 1'b1;
              tlast_r     <= (st_last_beat == '0);
              tdata_r     <= beat_data(cfg_seed, st_keep);
              tkeep_r     <= st_keep;
              tdest_r     <= cfg_tdest;
              tuser_r     <= '0;
              tid_r       <= cfg_tid;
            end
          end
        end
        SEND: begin
          if (stop) stop_q <= 1'b1;
          if (pkt_end) packets_sent <= sent_inc;
          if (run_end) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            stop_q   <= 1'b0;
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
          end else if (hs) begin
            if (pkt_end) begin
              pkt_base <= nb_base;
              tuser_r  <= sent_inc[TUSER_WIDTH-1:0];
            end
            beat_base <= nb_base;
            beat_k    <= nb_k;
            last_q    <= nb_last;
            tlast_r   <= nb_last;
            tdata_r   <= beat_data(nb_base, nb_keep);
            tkeep_r   <= nb_keep;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tx.tvalid = tvalid_r;
  assign tx.tdata  = tdata_r;
  assign tx.tkeep  = USE_TKEEP ? tkeep_r : '1;
  assign tx.tstrb  = USE_TSTRB ? tkeep_r : '1;
  assign tx.tlast  = USE_TLAST ? tlast_r : 1'b0;
  assign tx.tdest  = tdest_r;
  assign tx.tuser  = tuser_r;
  assign tx.tid    = tid_r;
endmodule

// File: tb/tb_logic_axi4_stream_packet_generator.sv
// Directed bench for the packet generator: framing, payload, stalls, stop, reset and start gating.
module tb_logic_axi4_stream_packet_generator;
  logic        aclk = 1'b0;
  logic        sreset, start, stop;
  logic [15:0] cfg_length, cfg_count;
  logic [7:0]  cfg_seed;
  logic        cfg_tdest, cfg_tid;
  logic        busy, done;
  logic [15:0] packets_sent;

  int tests = 0;
  int failures = 0;

  logic [31:0] exp_data [8];
  logic [3:0]  exp_keep [8];
  logic        exp_last [8];
  logic        exp_user [8];
  logic        exp_dest, exp_id;

  logic_axi4_stream_packet_generator_if #(.TDATA_BYTES(4), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .TID_WIDTH(1)) tx_if ();

  logic_axi4_stream_packet_generator dut (
    .aclk(aclk), .sreset(sreset), .start(start), .stop(stop),
    .cfg_length(cfg_length), .cfg_count(cfg_count), .cfg_seed(cfg_seed),
    .cfg_tdest(cfg_tdest), .cfg_tid(cfg_tid),
    .busy(busy), .done(done), .packets_sent(packets_sent),
    .tx(tx_if)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs until nb beats have been accepted; caller ends one cycle after the final handshake edge.
  task automatic run_beats(input int nb, input bit rnd);
    int idx = 0;
    int cyc = 0;
    logic stall = 1'b0;
    logic [31:0] held_d = '0;
    logic [3:0]  held_k = '0;
    logic        held_l = 1'b0;
    logic        held_u = 1'b0;
    while (idx < nb && cyc < 400) begin
      if (stall) begin
        check("stall_tvalid", tx_if.tvalid, 1'b1);
        check("stall_tdata", tx_if.tdata, held_d);
        check("stall_tkeep", tx_if.tkeep, held_k);
        check("stall_tlast", tx_if.tlast, held_l);
        check("stall_tuser", tx_if.tuser, held_u);
      end
      tx_if.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_if.tvalid && tx_if.tready) begin
        check("beat_tdata", tx_if.tdata, exp_data[idx]);
        check("beat_tkeep", tx_if.tkeep, exp_keep[idx]);
        check("beat_tstrb", tx_if.tstrb, exp_keep[idx]);
        check("beat_tlast", tx_if.tlast, exp_last[idx]);
        check("beat_tuser", tx_if.tuser, exp_user[idx]);
        check("beat_tdest", tx_if.tdest, exp_dest);
        check("beat_tid", tx_if.tid, exp_id);
        idx++;
      end
      if (!rnd) check("no_bubble_tvalid", tx_if.tvalid, 1'b1);
      stall  = tx_if.tvalid && !tx_if.tready;
      held_d = tx_if.tdata;
      held_k = tx_if.tkeep;
      held_l = tx_if.tlast;
      held_u = tx_if.tuser;
      tick();
      cyc++;
    end
    check("beats_complete_before_timeout", idx, nb);
    tx_if.tready = 1'b1;
  endtask

  task automatic pulse_start(input logic [15:0] len, input logic [15:0] cnt, input logic [7:0] seed,
                             input logic dst, input logic id);
    cfg_length = len; cfg_count = cnt; cfg_seed = seed; cfg_tdest = dst; cfg_tid = id;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_len10_seed10();
    exp_data[0] = 32'h13121110; exp_keep[0] = 4'hF; exp_last[0] = 1'b0; exp_user[0] = 1'b0;
    exp_data[1] = 32'h17161514; exp_keep[1] = 4'hF; exp_last[1] = 1'b0; exp_user[1] = 1'b0;
    exp_data[2] = 32'h00001918; exp_keep[2] = 4'h3; exp_last[2] = 1'b1; exp_user[2] = 1'b0;
    exp_data[3] = 32'h14131211; exp_keep[3] = 4'hF; exp_last[3] = 1'b0; exp_user[3] = 1'b1;
    exp_data[4] = 32'h18171615; exp_keep[4] = 4'hF; exp_last[4] = 1'b0; exp_user[4] = 1'b1;
    exp_data[5] = 32'h00001A19; exp_keep[5] = 4'h3; exp_last[5] = 1'b1; exp_user[5] = 1'b1;
    exp_dest = 1'b1; exp_id = 1'b0;
  endtask

  initial begin
    sreset = 1'b1; start = 1'b0; stop = 1'b0; tx_if.tready = 1'b1;
    cfg_length = '0; cfg_count = '0; cfg_seed = '0; cfg_tdest = 1'b0; cfg_tid = 1'b0;
    tick(); tick();
    check("reset_tvalid", tx_if.tvalid, 1'b0);
    check("reset_tdata", tx_if.tdata, 32'h0);
    check("reset_tkeep", tx_if.tkeep, 4'h0);
    check("reset_tlast", tx_if.tlast, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_packets_sent", packets_sent, 16'd0);
    sreset = 1'b0;
    tick();

    // Two 10-byte packets with tready held high.
    load_len10_seed10();
    pulse_start(16'd10, 16'd2, 8'h10, 1'b1, 1'b0);
    check("t1_first_beat_latency", tx_if.tvalid, 1'b1);
    check("t1_busy", busy, 1'b1);
    run_beats(6, 1'b0);
    check("t1_done", done, 1'b1);
    check("t1_busy_clear", busy, 1'b0);
    check("t1_tvalid_clear", tx_if.tvalid, 1'b0);
    check("t1_packets_sent", packets_sent, 16'd2);
    tick();
    check("t1_done_one_cycle", done, 1'b0);

    // Same run under random backpressure.
    pulse_start(16'd10, 16'd2, 8'h10, 1'b1, 1'b0);
    run_beats(6, 1'b1);
    check("t2_done", done, 1'b1);
    check("t2_packets_sent", packets_sent, 16'd2);
    tick();

    // Continuous 8-byte packets, stop pulsed on final beat of packet 3.
    exp_dest = 1'b0; exp_id = 1'b1;
    for (int i = 0; i < 7; i++) begin
      exp_data[i] = {8'((i / 2) + 4 * (i % 2) + 3), 8'((i / 2) + 4 * (i % 2) + 2),
                     8'((i / 2) + 4 * (i % 2) + 1), 8'((i / 2) + 4 * (i % 2))};
      exp_keep[i] = 4'hF;
      exp_last[i] = 1'(i % 2);
      exp_user[i] = 1'((i / 2) % 2);
    end
    pulse_start(16'd8, 16'd0, 8'h00, 1'b0, 1'b1);
    run_beats(7, 1'b0);
    check("t3_pkt3_beat1_data", tx_if.tdata, 32'h0A090807);
    check("t3_pkt3_beat1_last", tx_if.tlast, 1'b1);
    check("t3_pkt3_tuser", tx_if.tuser, 1'b1);
    check("t3_packets_sent_mid", packets_sent, 16'd3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t3_done", done, 1'b1);
    check("t3_tvalid_clear", tx_if.tvalid, 1'b0);
    check("t3_packets_sent", packets_sent, 16'd4);
    tick();
    check("t3_no_pkt4", tx_if.tvalid, 1'b0);
    check("t3_busy", busy, 1'b0);

    // Zero-length start.
    pulse_start(16'd0, 16'd3, 8'h55, 1'b0, 1'b0);
    check("t4_tvalid", tx_if.tvalid, 1'b0);
    check("t4_busy", busy, 1'b0);
    check("t4_done", done, 1'b1);
    check("t4_packets_sent", packets_sent, 16'd0);
    tick();
    check("t4_done_one_cycle", done, 1'b0);

    // Reset in the middle of packet 1.
    load_len10_seed10();
    pulse_start(16'd10, 16'd2, 8'h10, 1'b1, 1'b0);
    run_beats(4, 1'b0);
    check("t5_packets_sent_before", packets_sent, 16'd1);
    sreset = 1'b1;
    tick();
    sreset = 1'b0;
    check("t5_tvalid", tx_if.tvalid, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_packets_sent", packets_sent, 16'd0);
    check("t5_done", done, 1'b0);
    tick();
    check("t5_no_done_later", done, 1'b0);
    check("t5_stays_idle", tx_if.tvalid, 1'b0);

    // Single full-width beat with seed wrap; start re-pulsed while busy and on the final handshake.
    tx_if.tready = 1'b0;
    pulse_start(16'd4, 16'd1, 8'hFE, 1'b0, 1'b1);
    check("t6_tdata", tx_if.tdata, 32'h0100FFFE);
    check("t6_tkeep", tx_if.tkeep, 4'hF);
    check("t6_tlast", tx_if.tlast, 1'b1);
    pulse_start(16'd8, 16'd5, 8'h33, 1'b1, 1'b0);
    check("t6_held_tdata", tx_if.tdata, 32'h0100FFFE);
    check("t6_held_tvalid", tx_if.tvalid, 1'b1);
    tx_if.tready = 1'b1;
    pulse_start(16'd8, 16'd5, 8'h33, 1'b1, 1'b0);
    check("t6_done", done, 1'b1);
    check("t6_tvalid_clear", tx_if.tvalid, 1'b0);
    check("t6_packets_sent", packets_sent, 16'd1);
    tick();
    check("t6_second_start_ignored", tx_if.tvalid, 1'b0);
    check("t6_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
